mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//   Parametrised instruction-fetch stage for the pipelined MIPS core: PC generation plus a DEPTH-entry prefetch queue.
//   Decouples IMEM from decode with a valid/ready handshake and accepts redirects (branch/jump/jr) from ID.
//   Handles the architectural delay slot and, optionally, BTB prediction.
//   Sits between InstructionMemory (async read) and the ID stage; replaces the inline IF logic.
// PARAMETERS
//   ADDR_W      32            PC / address width
//   DEPTH       4             prefetch queue entries; power of 2, >=2
//   DELAY_SLOT  1             1: word after a redirecting instruction always executes; 0: no delay slot
//   RESET_PC    32'h0000_0000 first PC fetched after reset
//   BTB_ENTRIES 16            direct-mapped BTB entries, power of 2 (used only with FETCH_BTB_EN)
// PORTS
//   clk             in   1       clock
//   reset           in   1       async, active-high
//   imem_addr       out  ADDR_W  fetch PC to InstructionMemory
//   imem_rdata      in   32      instruction at imem_addr, same cycle
//   if_valid        out  1       queue head valid
//   id_ready        in   1       ID consumes head when if_valid&&id_ready
//   if_inst         out  32      head instruction
//   if_pc           out  ADDR_W  head PC
//   if_pc_4         out  ADDR_W  if_pc+4
//   if_pc_8         out  ADDR_W  if_pc+8 (link value)
//   if_pred_taken   out  1       head was predicted taken (0 without FETCH_BTB_EN)
//   redirect_valid  in   1       ID: stream after last consumed instr (+slot) is wrong
//   redirect_pc     in   ADDR_W  correct target
//   btb_upd_valid   in   1       resolve info from ID (ignored without FETCH_BTB_EN)
//   btb_upd_pc      in   ADDR_W  PC of resolved branch
//   btb_upd_target  in   ADDR_W  resolved target
//   btb_upd_taken   in   1       resolved direction
// BEHAVIOUR
//   Reset: fetch_pc=RESET_PC, queue empty, state RUN, if_valid=0, if_pred_taken=0, BTB valid bits clear.
//     Outputs zero on empty.
//   Fetch: in RUN, when not full (or full and popping), push {imem_rdata, fetch_pc}; fetch_pc+=4, mod 2^ADDR_W.
//   Latency: first if_valid one cycle after reset release, with if_pc=RESET_PC; push-to-head 1 cycle min.
//   Full+pop same cycle: push accepted, count unchanged. Empty: no bypass; pointers wrap mod DEPTH.
//   Redirect (highest priority): if_valid forced 0 that cycle, so no pop.
//     DELAY_SLOT=1, queue non-empty: keep head (slot) only, flush rest; fetch_pc<=redirect_pc.
//     DELAY_SLOT=1, queue empty: state SLOT_WAIT, tgt<=redirect_pc; next fetch pushes slot word at fetch_pc,
//       then fetch_pc<=tgt, state RUN.
//     DELAY_SLOT=0: flush all, fetch_pc<=redirect_pc.
//   Redirect during SLOT_WAIT overwrites tgt.
//   No redirect is needed for a correctly fetched stream; ID alone judges correctness.
//   Reset mid-operation: everything returns to reset state immediately; pending slot/target discarded.
// CONFIGURATION
//   FETCH_BTB_EN defined: BTB_ENTRIES direct-mapped {valid,tag,target}, indexed by fetch_pc[2+:log2(BTB_ENTRIES)].
//     Hit on push: entry pushed with pred_taken=1; with DELAY_SLOT=1 behaves as an internal redirect
//       (next word = slot, then target); DELAY_SLOT=0 -> next fetch_pc=target.
//     btb_upd_valid&&taken writes entry; &&!taken clears valid if tag matches.
//     Update and lookup same index same cycle: lookup sees old value.
//   Undefined: no BTB storage, if_pred_taken tied 0, btb_upd_* ignored.
// STRUCTURE
//   mips_pkg: state enum {RUN, SLOT_WAIT}, INST_NOP=32'h0, default RESET_PC constant, PC_STEP=4.
//   Sub-module fetch_queue (DEPTH-entry FIFO: push, pop, flush_all, flush_keep_head, full, empty).
//   Top holds PC, FSM, BTB.
// TESTING
//   Reset, id_ready=1, sequential IMEM -> if_valid at cycle 1; if_pc 0,4,8,... one per cycle.
//   id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries held; no PC 0x10 lost on resume.
//   Redirect to 0x100 with queue {0x08,0x0C,0x10} -> next heads 0x08 (slot), then 0x100.
//   Redirect with empty queue, fetch_pc=0x20 -> heads 0x20 (slot) then 0x200; DELAY_SLOT=0 -> 0x200 directly.
//   FETCH_BTB_EN: update pc=0x40 target 0x80 taken; refetch -> 0x40 (pred=1), 0x44, 0x80.
//   Reset asserted mid-SLOT_WAIT -> queue empty, next head RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS fetch stage
package mips_pkg;
  typedef enum logic {RUN, SLOT_WAIT} fetch_state_t;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/mips_fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch FIFO with full flush and keep-head flush
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush_all,
  input  logic         flush_keep_head,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [PW:0] cnt;
  logic wr_en, rd_en, flush;
  assign flush = flush_all || flush_keep_head;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rd];
  assign wr_en = push && !flush && (!full || pop);
  assign rd_en = pop && !empty && !flush;
  // pointers and occupancy; keep-head flush trims the queue to its current head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else if (flush_all) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else if (flush_keep_head) begin
      wr <= empty ? rd : rd + PW'(1);
      cnt <= empty ? '0 : (PW+1)'(1);
    end else begin
      wr <= wr_en ? wr + PW'(1) : wr;
      rd <= rd_en ? rd + PW'(1) : rd;
      cnt <= cnt + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
  end
  // entry storage, no reset needed since empty entries are never exposed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr] <= din;
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC generation, delay-slot handling and prefetch queue; optional BTB under FETCH_BTB_EN
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter int DELAY_SLOT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_4,
  output logic [ADDR_W-1:0] if_pc_8,
  output logic              if_pred_taken,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              btb_upd_valid,
  input  logic [ADDR_W-1:0] btb_upd_pc,
  input  logic [ADDR_W-1:0] btb_upd_target,
  input  logic              btb_upd_taken
);
  localparam int EW = ADDR_W + 33;
  fetch_state_t st;
  logic [ADDR_W-1:0] fetch_pc, tgt, pc_next, btb_tgt;
  logic [EW-1:0] q_din, q_dout;
  logic q_full, q_empty, push, pop, btb_hit;
  assign imem_addr = fetch_pc;
  assign if_valid = !q_empty && !redirect_valid;
  assign pop = if_valid && id_ready;
  assign push = !redirect_valid && (!q_full || pop);
  assign pc_next = fetch_pc + ADDR_W'(PC_STEP);
  assign q_din = {btb_hit, fetch_pc, imem_rdata};
  assign if_inst = q_empty ? INST_NOP : q_dout[31:0];
  assign if_pc = q_empty ? '0 : q_dout[32 +: ADDR_W];
  assign if_pc_4 = q_empty ? '0 : q_dout[32 +: ADDR_W] + ADDR_W'(PC_STEP);
  assign if_pc_8 = q_empty ? '0 : q_dout[32 +: ADDR_W] + ADDR_W'(2 * PC_STEP);
  assign if_pred_taken = !q_empty && q_dout[EW-1];
  fetch_queue #(.DEPTH(DEPTH), .W(EW)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush_all(redirect_valid && DELAY_SLOT == 0),
    .flush_keep_head(redirect_valid && DELAY_SLOT != 0),
    .din(q_din),
    .dout(q_dout),
    .full(q_full),
    .empty(q_empty)
  );
`ifdef FETCH_BTB_EN
  localparam int BIW = $clog2(BTB_ENTRIES);
  localparam int TW = ADDR_W - 2 - BIW;
  logic [BTB_ENTRIES-1:0] btb_v;
  logic [TW-1:0] btb_tag [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_target [BTB_ENTRIES];
  logic [BIW-1:0] lk_idx, up_idx;
  logic [TW-1:0] up_tag;
  assign lk_idx = fetch_pc[2 +: BIW];
  assign up_idx = btb_upd_pc[2 +: BIW];
  assign up_tag = btb_upd_pc[ADDR_W-1 -: TW];
  assign btb_hit = st == RUN && btb_v[lk_idx] && btb_tag[lk_idx] == fetch_pc[ADDR_W-1 -: TW];
  assign btb_tgt = btb_target[lk_idx];
  // valid bits: taken resolve installs, not-taken resolve evicts a matching entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btb_v <= '0;
    else if (btb_upd_valid && btb_upd_taken) btb_v[up_idx] <= 1'b1;
    else if (btb_upd_valid && btb_tag[up_idx] == up_tag) btb_v[up_idx] <= 1'b0;
  end
  // tag and target payload written on taken resolves
  always_ff @(posedge clk) begin
    if (btb_upd_valid && btb_upd_taken) begin
      btb_tag[up_idx] <= up_tag;
      btb_target[up_idx] <= btb_upd_target;
    end
  end
`else
  logic unused_btb;
  assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;
`endif
  // PC and slot FSM: redirect wins, otherwise advance on every accepted push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= RUN;
      fetch_pc <= RESET_PC;
      tgt <= '0;
    end else if (redirect_valid) begin
      if (DELAY_SLOT != 0 && q_empty) begin
        st <= SLOT_WAIT;
        tgt <= redirect_pc;
      end else begin
        st <= RUN;
        fetch_pc <= redirect_pc;
      end
    end else if (push) begin
      if (st == SLOT_WAIT) begin
        st <= RUN;
        fetch_pc <= tgt;
      end else if (btb_hit && DELAY_SLOT != 0) begin
        st <= SLOT_WAIT;
        tgt <= btb_tgt;
        fetch_pc <= pc_next;
      end else fetch_pc <= btb_hit ? btb_tgt : pc_next;
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed checks of fetch sequencing, backpressure, redirects and reset
module tb_mips_fetch_unit;
  logic clk = 1'b0;
  logic reset, id_ready, redirect_valid, btb_upd_valid, btb_upd_taken;
  logic [31:0] redirect_pc, btb_upd_pc, btb_upd_target;
  logic [31:0] imem_addr, imem_rdata, if_inst, if_pc, if_pc_4, if_pc_8;
  logic if_valid, if_pred_taken;
  logic [31:0] d0_addr, d0_rdata, d0_inst, d0_pc, d0_pc_4, d0_pc_8;
  logic d0_valid, d0_pred;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;
  assign d0_rdata = d0_addr ^ 32'hDEAD_0000;
  mips_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .id_ready(id_ready), .if_inst(if_inst), .if_pc(if_pc),
    .if_pc_4(if_pc_4), .if_pc_8(if_pc_8), .if_pred_taken(if_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken)
  );
  mips_fetch_unit #(.DELAY_SLOT(0)) dut_ds0 (
    .clk(clk), .reset(reset), .imem_addr(d0_addr), .imem_rdata(d0_rdata),
    .if_valid(d0_valid), .id_ready(id_ready), .if_inst(d0_inst), .if_pc(d0_pc),
    .if_pc_4(d0_pc_4), .if_pc_8(d0_pc_8), .if_pred_taken(d0_pred),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_head(input string tag, input logic [31:0] pc);
    #1;
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_inst"}, if_inst, pc ^ 32'hDEAD_0000);
    check({tag, "_pc8"}, if_pc_8, pc + 32'd8);
  endtask
  task automatic rst_seq;
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    btb_upd_valid = 1'b0;
    btb_upd_taken = 1'b0;
    btb_upd_pc = '0;
    btb_upd_target = '0;
    step();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pred", 32'(if_pred_taken), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_head("seq", 32'(4 * k));
      check("seq_pc4", if_pc_4, 32'(4 * k + 4));
      check("seq_pred", 32'(if_pred_taken), 32'd0);
    end
    rst_seq();
    id_ready = 1'b0;
    repeat (10) step();
    chk_head("bp_hold", 32'h0);
    check("bp_addr", imem_addr, 32'h10);
    id_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_head("bp_resume", 32'(4 * k));
    end
    rst_seq();
    id_ready = 1'b0;
    repeat (3) step();
    id_ready = 1'b1;
    repeat (2) step();
    chk_head("rd_pre", 32'h8);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("rd_force", 32'(if_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk_head("rd_slot", 32'h8);
    check("rd_addr", imem_addr, 32'h100);
    check("ds0_rd_empty", 32'(d0_valid), 32'd0);
    check("ds0_rd_addr", d0_addr, 32'h100);
    step();
    chk_head("rd_tgt", 32'h100);
    check("ds0_rd_tgt", d0_pc, 32'h100);
    check("ds0_rd_valid", 32'(d0_valid), 32'd1);
    step();
    chk_head("rd_next", 32'h104);
    rst_seq();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check("sw_force", 32'(if_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("sw_empty", 32'(if_valid), 32'd0);
    check("sw_addr", imem_addr, 32'h0);
    check("ds0_sw_addr", d0_addr, 32'h200);
    step();
    chk_head("sw_slot", 32'h0);
    check("sw_addr2", imem_addr, 32'h200);
    check("ds0_sw_head", d0_pc, 32'h200);
    step();
    chk_head("sw_tgt", 32'h200);
    step();
    chk_head("sw_next", 32'h204);
    rst_seq();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    step();
    chk_head("ow_slot", 32'h0);
    step();
    chk_head("ow_tgt", 32'h300);
    rst_seq();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mr_valid", 32'(if_valid), 32'd0);
    check("mr_addr", imem_addr, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk_head("mr_first", 32'h0);
    step();
    chk_head("mr_second", 32'h4);
`ifdef FETCH_BTB_EN
    rst_seq();
    btb_upd_valid = 1'b1;
    btb_upd_taken = 1'b1;
    btb_upd_pc = 32'h40;
    btb_upd_target = 32'h80;
    step();
    btb_upd_valid = 1'b0;
    repeat (16) step();
    chk_head("btb_br", 32'h40);
    check("btb_pred", 32'(if_pred_taken), 32'd1);
    step();
    chk_head("btb_slot", 32'h44);
    check("btb_slot_pred", 32'(if_pred_taken), 32'd0);
    step();
    chk_head("btb_tgt", 32'h80);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
